// File: rtl/gemb_defs.sv
// gemb_defs: shared constants, loader states and opcode values for the program-load path.
package gemb_defs;
    localparam int DEF_MEM_DEPTH = 32512;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_HLT = 8'h01;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } ld_state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: parses SYNC/ADDR/LEN/payload/CHK frames into memory writes, then releases cpu_rst.
module prog_loader
    import gemb_defs::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic        CLK100MHZ,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    ld_state_t   state_q, state_d;
    logic [7:0]  acc_q, acc_d, mem_wdata_q, mem_wdata_d;
    logic [15:0] addr_q, addr_d, len_q, len_d, mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d, cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        xfer;
    logic [15:0] len_full;
    logic [7:0]  acc_sum;

    assign rx_ready = !rst && state_q != S_DONE && state_q != S_ERR;
    assign xfer     = rx_valid && rx_ready;
    assign len_full = {rx_data, len_q[7:0]};
    assign acc_sum  = acc_q + rx_data;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        addr_d      = addr_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        if (xfer) begin
            case (state_q)
                S_IDLE: if (rx_data == SYNC_BYTE) begin
                    state_d   = S_ADDR0;
                    busy_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                    err_d     = 1'b0;
                    acc_d     = 8'd0;
                end
                S_ADDR0: begin
                    addr_d[7:0] = rx_data;
                    acc_d       = acc_sum;
                    state_d     = S_ADDR1;
                end
                S_ADDR1: begin
                    addr_d[15:8] = rx_data;
                    acc_d        = acc_sum;
                    state_d      = S_LEN0;
                end
                S_LEN0: begin
                    len_d[7:0] = rx_data;
                    acc_d      = acc_sum;
                    state_d    = S_LEN1;
                end
                S_LEN1: begin
                    len_d  = len_full;
                    acc_d  = acc_sum;
                    // 17-bit sum so a header near 64K cannot wrap into range
                    if ({1'b0, addr_q} + {1'b0, len_full} > 17'(MEM_DEPTH)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = (len_full == 16'd0) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = rx_data;
                    addr_d      = addr_q + 16'd1;
                    len_d       = len_q - 16'd1;
                    acc_d       = acc_sum;
                    state_d     = (len_q == 16'd1) ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    busy_d = 1'b0;
                    if (acc_sum == 8'd0) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_DONE || state_q == S_ERR) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= 8'd0;
            addr_q      <= 16'd0;
            len_q       <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: frame-level reference model checks loader writes and status against random frames.
module tb_prog_loader;
    import gemb_defs::*;
    localparam int MEM_DEPTH = DEF_MEM_DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_rst, busy, done, err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    int n_tot = 0;
    int n_bad = 0;
    logic [7:0] pl[$];
    int exp_q[$];

    always #5 clk = ~clk;

    prog_loader dut (
        .CLK100MHZ(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next expected (addr,data) of the model.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) chk("unexp_we", 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
                int e;
                e = exp_q.pop_front();
                chk("waddr", 32'(mem_addr), 32'(e >> 8));
                chk("wdata", 32'(mem_wdata), 32'(e & 8'hFF));
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("ready_timeout", 0, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame(input int addr, input int len, input bit bad, input int gapmax, input int noise);
        logic [7:0] s, c;
        logic [7:0] nz[3];
        bit rng, fail;
        nz[0] = 8'h00; nz[1] = 8'hFF; nz[2] = 8'h13;
        rng = (addr + len) > MEM_DEPTH;
        fail = rng || bad;
        while (pl.size() < len) pl.push_back(8'($urandom));
        s = 8'(addr) + 8'(addr >> 8) + 8'(len) + 8'(len >> 8);
        foreach (pl[i]) s += pl[i];
        c = 8'd0 - s;
        if (bad) c = c + 8'd1;
        if (!rng) for (int i = 0; i < len; i++) exp_q.push_back(((addr + i) << 8) | int'(pl[i]));
        for (int i = 0; i < noise; i++) send(nz[i % 3], $urandom_range(0, gapmax));
        chk("noise_idle", 32'(busy), 0);
        send(SYNC_BYTE, $urandom_range(0, gapmax));
        chk("sync_busy", 32'(busy), 1);
        chk("sync_cpurst", 32'(cpu_rst), 1);
        chk("sync_err", 32'(err), 0);
        send(8'(addr), $urandom_range(0, gapmax));
        send(8'(addr >> 8), $urandom_range(0, gapmax));
        send(8'(len), $urandom_range(0, gapmax));
        send(8'(len >> 8), $urandom_range(0, gapmax));
        if (!rng) begin
            for (int i = 0; i < len; i++) send(pl[i], $urandom_range(0, gapmax));
            send(c, $urandom_range(0, gapmax));
        end
        chk("end_done", 32'(done), 32'(!fail));
        chk("end_err", 32'(err), 32'(fail));
        chk("end_cpurst", 32'(cpu_rst), 32'(fail));
        chk("end_busy", 32'(busy), 0);
        chk("end_rdy", 32'(rx_ready), 0);
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_err", 32'(err), 32'(fail));
        chk("post_cpurst", 32'(cpu_rst), 32'(fail));
        chk("post_rdy", 32'(rx_ready), 1);
        chk("writes_left", 32'(exp_q.size()), 0);
        exp_q.delete();
        pl.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rx_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_rdy_after", 32'(rx_ready), 1);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_cpurst", 32'(cpu_rst), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);

        pl = {8'h00, 8'h01};
        frame(0, 2, 0, 0, 0);
        pl = {8'h00, 8'h01};
        frame(0, 2, 1, 0, 0);
        frame(32'h7EFF, 1, 0, 1, 0);
        frame(32'h7F00, 1, 0, 1, 0);
        frame(32'h0010, 0, 0, 0, 0);
        frame(32'h0100, 5, 0, 3, 3);
        frame(32'hFFFF, 2, 0, 0, 0);

        // reset in the middle of a 3-byte payload
        exp_q.push_back((32'h20 << 8) | 32'h11);
        send(SYNC_BYTE, 0);
        send(8'h20, 0);
        send(8'h00, 0);
        send(8'h03, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h22;
        #1;
        chk("mr_rdy", 32'(rx_ready), 0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_cpurst", 32'(cpu_rst), 1);
        chk("mr_err", 32'(err), 0);
        chk("mr_we", 32'(mem_we), 0);
        chk("mr_left", 32'(exp_q.size()), 0);
        rst = 1'b0;
        @(negedge clk);
        frame(32'h40, 3, 0, 1, 0);

        for (int k = 0; k < 25; k++) begin
            int a, l;
            l = $urandom_range(0, 6);
            a = ($urandom_range(0, 3) == 0) ? MEM_DEPTH - l + $urandom_range(0, 1)
                                            : $urandom_range(0, MEM_DEPTH - 1);
            frame(a, l, $urandom_range(0, 3) == 0, 2, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
